// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: address
// field positions, controller states and storage types.
package icache_pkg;

  localparam int unsigned TAG_MSB  = 15;
  localparam int unsigned TAG_LSB  = 6;
  localparam int unsigned IDX_MSB  = 5;
  localparam int unsigned IDX_LSB  = 3;
  localparam int unsigned WORD_MSB = 2;
  localparam int unsigned WORD_LSB = 1;
  localparam int unsigned TAG_W    = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned IDX_W    = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    FILL0,
    FILL1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef logic [63:0] line_t;

  // Pick 16-bit word w out of a line; word w sits at bits [16w+15:16w].
  function automatic logic [15:0] sel_word(input line_t line, input logic [1:0] w);
    logic [15:0] r;
    case (w)
      2'd0:    r = line[15:0];
      2'd1:    r = line[31:16];
      2'd2:    r = line[47:32];
      default: r = line[63:48];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// CPU fetch port and memory refill port of the instruction cache.
interface icache_ctrl_if;
  logic [15:0] cpu_req_addr;
  logic        cpu_req_rw;
  logic        cpu_req_valid;
  logic [15:0] cpu_res_data;
  logic        cpu_res_ready;
  logic [15:0] mem_req_addr;
  logic        mem_req_rw;
  logic        mem_req_valid;
  logic [31:0] mem_res_data;
  logic        mem_res_ready;

  // Requester side: issues CPU fetches and answers memory refill beats.
  modport master (
    output cpu_req_addr, cpu_req_rw, cpu_req_valid,
    input  cpu_res_data, cpu_res_ready,
    input  mem_req_addr, mem_req_rw, mem_req_valid,
    output mem_res_data, mem_res_ready
  );

  // Cache side.
  modport slave (
    input  cpu_req_addr, cpu_req_rw, cpu_req_valid,
    output cpu_res_data, cpu_res_ready,
    output mem_req_addr, mem_req_rw, mem_req_valid,
    input  mem_res_data, mem_res_ready
  );
endinterface

// File: rtl/icache_array.sv
// Tag/valid and data storage: asynchronous read by index, synchronous
// full-line write, valid bits cleared by reset or a single-cycle flush.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned NLINES = 8,
  localparam int unsigned IW = $clog2(NLINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    rd_idx,
  output tag_entry_t       rd_entry,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line,
  input  logic             clear
);

  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0]  tags [NLINES];
  line_t             data [NLINES];

  // Valid bits: the only storage that needs a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written together when a refill completes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end
  end

  assign rd_entry = '{valid: valid[rd_idx], tag: tags[rd_idx]};
  assign rd_line  = data[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: lookup FSM,
// two-beat line refill, flush handling and saturating hit/miss counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned NLINES = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  icache_ctrl_if.slave     bus,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_t           state;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_word;
  logic             req_rw;
  logic [31:0]      beat0;

  tag_entry_t       rd_entry;
  line_t            rd_line;
  logic             lookup_hit;
  logic             fill_done;
  logic             flush_now;

  assign lookup_hit = rd_entry.valid && (rd_entry.tag == req_tag);
  assign fill_done  = (state == FILL1) && bus.mem_res_ready;
  assign flush_now  = (state == IDLE) && flush;
  assign bus.mem_req_rw = 1'b0;

  icache_array #(.NLINES(NLINES)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx),
    .rd_entry (rd_entry),
    .rd_line  (rd_line),
    .wr_en    (fill_done),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_line  ({bus.mem_res_data, beat0}),
    .clear    (flush_now)
  );

  // Controller FSM with registered CPU/memory outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_tag           <= '0;
      req_idx           <= '0;
      req_word          <= '0;
      req_rw            <= 1'b0;
      beat0             <= '0;
      bus.cpu_res_ready <= 1'b0;
      bus.cpu_res_data  <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      hit_count         <= '0;
      miss_count        <= '0;
    end else begin
      bus.cpu_res_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Flush (handled by the array) wins over a pending request.
          if (!flush && bus.cpu_req_valid && !bus.cpu_res_ready) begin
            req_tag  <= bus.cpu_req_addr[TAG_MSB:TAG_LSB];
            req_idx  <= bus.cpu_req_addr[IDX_MSB:IDX_LSB];
            req_word <= bus.cpu_req_addr[WORD_MSB:WORD_LSB];
            req_rw   <= bus.cpu_req_rw;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (req_rw) begin
            bus.cpu_res_ready <= 1'b1;
            bus.cpu_res_data  <= '0;
            state             <= IDLE;
          end else if (lookup_hit) begin
            bus.cpu_res_ready <= 1'b1;
            bus.cpu_res_data  <= sel_word(rd_line, req_word);
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            state             <= IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= {req_tag, req_idx, 3'b000};
            state             <= FILL0;
          end
        end
        FILL0: begin
          if (bus.mem_res_ready) begin
            beat0            <= bus.mem_res_data;
            bus.mem_req_addr <= {req_tag, req_idx, 3'b100};
            state            <= FILL1;
          end
        end
        FILL1: begin
          // The line is written by the array on this edge; the following
          // COMPARE re-lookup then hits and answers the CPU.
          if (bus.mem_res_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            state             <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized scoreboard bench for icache_ctrl. A second instance with a
// 3-bit counter width shares the same stimulus to exercise saturation.
module tb_icache_ctrl;

  localparam int unsigned SAT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [15:0]      hit_count, miss_count;
  logic [SAT_W-1:0] hit_small, miss_small;

  icache_ctrl_if bus ();
  icache_ctrl_if bus2 ();

  always #5 clk = ~clk;

  icache_ctrl #(.NLINES(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  icache_ctrl #(.NLINES(8), .CNT_W(SAT_W)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus2),
    .flush      (flush),
    .hit_count  (hit_small),
    .miss_count (miss_small)
  );

  assign bus2.cpu_req_addr  = bus.cpu_req_addr;
  assign bus2.cpu_req_rw    = bus.cpu_req_rw;
  assign bus2.cpu_req_valid = bus.cpu_req_valid;
  assign bus2.mem_res_data  = bus.mem_res_data;
  assign bus2.mem_res_ready = bus.mem_res_ready;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Memory is a fixed byte-addressed store; the cache is a set of
  // (index -> tag) residencies. Reads return memory contents regardless.
  logic [31:0] mem_pre [logic [15:0]];
  bit          mvalid [8];
  logic [9:0]  mtag [8];
  int unsigned mhits, mmiss;

  typedef struct {
    logic [15:0] data;
    int unsigned hits;
    int unsigned miss;
    int          lat;
    int          raise;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_exp_q[$];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return {a ^ 16'h5A3C, ~a + 16'h0137};
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    mhits = 0;
    mmiss = 0;
  endtask

  task automatic model_flush();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  task automatic model_req(input logic [15:0] a, input logic rw, input int rc);
    exp_t        e;
    logic [2:0]  idx;
    logic [9:0]  tg;
    logic [15:0] base;
    logic [31:0] w;
    idx = a[5:3];
    tg  = a[15:6];
    e.raise = rc;
    e.lat   = 2;
    if (rw) begin
      e.data = 16'h0000;
    end else begin
      if (!(mvalid[idx] && mtag[idx] == tg)) begin
        base = {a[15:3], 3'b000};
        mem_exp_q.push_back(base);
        mem_exp_q.push_back(base + 16'd4);
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        mmiss++;
        e.lat = -1;
      end
      mhits++;
      w = mem_word({a[15:2], 2'b00});
      e.data = a[1] ? w[31:16] : w[15:0];
    end
    e.hits = mhits;
    e.miss = mmiss;
    exp_q.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  bit mem_hold = 1'b0;
  int mem_wait = 0;

  always @(negedge clk) begin
    logic [15:0] ea;
    bus.mem_res_ready = 1'b0;
    if (rst_n && bus.mem_req_valid && !mem_hold) begin
      if (mem_wait > 0) begin
        mem_wait--;
      end else begin
        if (mem_exp_q.size() == 0) begin
          checks++;
          $display("FAIL mem_unexpected: got request at %0h expected no memory traffic", bus.mem_req_addr);
        end else begin
          ea = mem_exp_q.pop_front();
          check("mem_addr", bus.mem_req_addr, ea);
        end
        check("mem_rw", bus.mem_req_rw, 1'b0);
        bus.mem_res_data  = mem_word(bus.mem_req_addr);
        bus.mem_res_ready = 1'b1;
        mem_wait = $urandom_range(0, 2);
      end
    end
  end

  // ---------------- response monitor ----------------
  bit prev_ready = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.cpu_res_ready) begin
      check("ready_pulse", prev_ready, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL resp_unexpected: got data %0h expected no response", bus.cpu_res_data);
      end else begin
        e = exp_q.pop_front();
        check("res_data", bus.cpu_res_data, e.data);
        check("hit_count", hit_count, e.hits);
        check("miss_count", miss_count, e.miss);
        check("hit_sat", hit_small, sat(e.hits, SAT_W));
        check("miss_sat", miss_small, sat(e.miss, SAT_W));
        if (e.lat >= 0) check("hit_latency", cyc - e.raise, e.lat);
      end
    end
    prev_ready = rst_n && bus.cpu_res_ready;
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [15:0] a, input logic rw, input bit fl);
    bit done = 1'b0;
    bit flushing = 1'b0;
    @(negedge clk);
    bus.cpu_req_addr  = a;
    bus.cpu_req_rw    = rw;
    model_req(a, rw, cyc);
    bus.cpu_req_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.cpu_res_ready) begin
        done = 1'b1;
      end else if (fl && !flushing && bus.mem_req_valid && bus.mem_req_addr[2]) begin
        flush    = 1'b1;
        flushing = 1'b1;
        model_flush();
      end
    end
    bus.cpu_req_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL req_timeout: got no response for addr %0h expected one within 200 cycles", a);
      exp_q.delete();
      mem_exp_q.delete();
    end
    if (flushing) begin
      @(negedge clk);
      flush = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_flush();
    @(negedge clk);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"},    bus.cpu_res_ready, 1'b0);
    check({tag, "_data"},     bus.cpu_res_data, 16'h0);
    check({tag, "_memvalid"}, bus.mem_req_valid, 1'b0);
    check({tag, "_memaddr"},  bus.mem_req_addr, 16'h0);
    check({tag, "_memrw"},    bus.mem_req_rw, 1'b0);
    check({tag, "_hits"},     hit_count, 16'h0);
    check({tag, "_misses"},   miss_count, 16'h0);
  endtask

  initial begin
    bit seen;
    logic [15:0] a;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.mem_res_data  = '0;
    bus.mem_res_ready = 1'b0;
    model_reset();
    mem_pre[16'h0040] = 32'h11112222;
    mem_pre[16'h0044] = 32'h33334444;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Cold miss, hit, eviction by a conflicting tag, re-miss.
    do_req(16'h0042, 1'b0, 1'b0);
    do_req(16'h0040, 1'b0, 1'b0);
    do_req(16'h0080, 1'b0, 1'b0);
    do_req(16'h0040, 1'b0, 1'b0);
    check("evict_misses", miss_count, 16'd3);

    // Flush raised while the second beat is outstanding.
    do_req(16'h0100, 1'b0, 1'b1);
    do_req(16'h0100, 1'b0, 1'b0);

    // Write is answered with zero and leaves the line resident.
    do_req(16'h0040, 1'b0, 1'b0);
    do_req(16'h0040, 1'b1, 1'b0);
    do_req(16'h0046, 1'b0, 1'b0);

    // Asynchronous reset while the first refill beat is pending.
    mem_hold = 1'b1;
    @(negedge clk);
    bus.cpu_req_addr  = 16'h0200;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_req_valid;
    end
    check("fill0_reached", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    bus.cpu_req_valid = 1'b0;
    model_reset();
    exp_q.delete();
    mem_exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    do_req(16'h0200, 1'b0, 1'b0);
    do_req(16'h0040, 1'b0, 1'b0);

    // Randomized traffic over a small tag range to mix hits and misses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 5) idle_flush();
      a = 16'($urandom());
      a[15:6] = 10'($urandom_range(0, 3));
      do_req(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", mem_exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before 5ms");
    $fatal(1);
  end

endmodule
